// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds default mode timings and the counter-width check used at elaboration.
package vga_pkg;

    // 640x480@60, 25 MHz pixel rate from a 50 MHz system clock
    localparam int VGA640_PIX_DIV    = 2;
    localparam int VGA640_H_ACTIVE   = 640;
    localparam int VGA640_H_FP       = 16;
    localparam int VGA640_H_SYNC     = 96;
    localparam int VGA640_H_BP       = 48;
    localparam int VGA640_V_ACTIVE   = 480;
    localparam int VGA640_V_FP       = 10;
    localparam int VGA640_V_SYNC     = 2;
    localparam int VGA640_V_BP       = 33;
    localparam bit VGA640_H_SYNC_POL = 1'b0;
    localparam bit VGA640_V_SYNC_POL = 1'b0;

    // 800x600@60, 40 MHz pixel rate from an 80 MHz system clock
    localparam int SVGA800_PIX_DIV    = 2;
    localparam int SVGA800_H_ACTIVE   = 800;
    localparam int SVGA800_H_FP       = 40;
    localparam int SVGA800_H_SYNC     = 128;
    localparam int SVGA800_H_BP       = 88;
    localparam int SVGA800_V_ACTIVE   = 600;
    localparam int SVGA800_V_FP       = 1;
    localparam int SVGA800_V_SYNC     = 4;
    localparam int SVGA800_V_BP       = 23;
    localparam bit SVGA800_H_SYNC_POL = 1'b1;
    localparam bit SVGA800_V_SYNC_POL = 1'b1;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic video_on;
    } vga_decode_t;

    function automatic bit fits_width(input int total, input int width);
        if (width >= 31) return 1'b1;
        return total <= (1 << width);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator and the pixel/colour generator.
// Carries frame_cnt only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int COORD_W = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    parameter int FRAME_CNT_W = 8
`endif
);
    logic               en;
    logic               h_sync;
    logic               v_sync;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               video_on;
    logic               pix_stb;
    logic               line_start;
    logic               frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  en,
        output h_sync, v_sync, pixel_x, pixel_y, video_on,
               pix_stb, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  h_sync, v_sync, pixel_x, pixel_y, video_on,
               pix_stb, line_start, frame_start, frame_cnt
    );
`else
    modport master (
        input  en,
        output h_sync, v_sync, pixel_x, pixel_y, video_on,
               pix_stb, line_start, frame_start
    );

    modport slave (
        output en,
        input  h_sync, v_sync, pixel_x, pixel_y, video_on,
               pix_stb, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_pix_prescaler.sv
// Integer divider producing the pixel-rate clock enable from the system clock.
// Counting pauses while en is low so the pixel phase is preserved.
module vga_pix_prescaler #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic ce
);

    if (PIX_DIV == 1) begin : g_pass
        assign ce = en;
    end else begin : g_div
        localparam int CW = $clog2(PIX_DIV);

        logic [CW-1:0] div_cnt_q;
        logic [CW-1:0] div_cnt_d;
        logic          div_last;

        assign div_last = (div_cnt_q == CW'(PIX_DIV - 1));

        always_comb begin
            div_cnt_d = div_cnt_q;
            if (en) begin
                div_cnt_d = div_last ? '0 : div_cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_d;
            end
        end

        assign ce = en && div_last;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaler, h/v counters, registered decode.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV    = VGA640_PIX_DIV,
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit H_SYNC_POL = VGA640_H_SYNC_POL,
    parameter bit V_SYNC_POL = VGA640_V_SYNC_POL,
    parameter int COORD_W    = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    parameter int FRAME_CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga_if
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    if (PIX_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end
    if (!fits_width(H_TOTAL, COORD_W) || !fits_width(V_TOTAL, COORD_W)) begin : g_bad_width
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam vga_decode_t DEC_RESET = '{h_sync: ~H_SYNC_POL, v_sync: ~V_SYNC_POL, video_on: 1'b0};

    logic ce;

    vga_pix_prescaler #(
        .PIX_DIV(PIX_DIV)
    ) u_prescaler (
        .clk(clk),
        .rst(rst),
        .en (vga_if.en),
        .ce (ce)
    );

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic [COORD_W-1:0] pixel_x_q, pixel_x_d;
    logic [COORD_W-1:0] pixel_y_q, pixel_y_d;
    vga_decode_t        dec_q, dec_d, dec_now;
    logic               pix_stb_q, pix_stb_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               h_last, v_last, at_origin;

    assign h_last    = (h_cnt_q == COORD_W'(H_TOTAL - 1));
    assign v_last    = (v_cnt_q == COORD_W'(V_TOTAL - 1));
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        dec_now.video_on = (h_cnt_q < COORD_W'(H_ACTIVE)) && (v_cnt_q < COORD_W'(V_ACTIVE));
        dec_now.h_sync   = ((h_cnt_q >= COORD_W'(H_SYNC_START)) && (h_cnt_q < COORD_W'(H_SYNC_END)))
                           ? H_SYNC_POL : ~H_SYNC_POL;
        dec_now.v_sync   = ((v_cnt_q >= COORD_W'(V_SYNC_START)) && (v_cnt_q < COORD_W'(V_SYNC_END)))
                           ? V_SYNC_POL : ~V_SYNC_POL;
    end

    // Outputs capture the current position before the counters advance past it.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        dec_d         = dec_q;
        pix_stb_d     = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce) begin
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            dec_d         = dec_now;
            pix_stb_d     = 1'b1;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = at_origin;
            h_cnt_d       = h_last ? '0 : h_cnt_q + COORD_W'(1);
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            dec_q         <= DEC_RESET;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            dec_q         <= dec_d;
            pix_stb_q     <= pix_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_if.pixel_x     = pixel_x_q;
    assign vga_if.pixel_y     = pixel_y_q;
    assign vga_if.h_sync      = dec_q.h_sync;
    assign vga_if.v_sync      = dec_q.v_sync;
    assign vga_if.video_on    = dec_q.video_on;
    assign vga_if.pix_stb     = pix_stb_q;
    assign vga_if.line_start  = line_start_q;
    assign vga_if.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // The first frame after reset is still in progress, so it is not counted.
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   seen_first_q, seen_first_d;

    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        seen_first_d = seen_first_q;
        if (ce && at_origin) begin
            seen_first_d = 1'b1;
            if (seen_first_q) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q  <= '0;
            seen_first_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            seen_first_q <= seen_first_d;
        end
    end

    assign vga_if.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny PIX_DIV=1 positive-hsync instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef VGA_TIMING_FRAME_CNT_EN
    vga_timing_gen_if #(.COORD_W(10), .FRAME_CNT_W(8)) ifa ();
    vga_timing_gen_if #(.COORD_W(4), .FRAME_CNT_W(4)) ifb ();
`else
    vga_timing_gen_if #(.COORD_W(10)) ifa ();
    vga_timing_gen_if #(.COORD_W(4)) ifb ();
`endif

    vga_timing_gen u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .vga_if(ifa)
    );

    vga_timing_gen #(
        .PIX_DIV   (1),
        .H_ACTIVE  (8),
        .H_FP      (1),
        .H_SYNC    (2),
        .H_BP      (1),
        .V_ACTIVE  (4),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .H_SYNC_POL(1'b1),
        .V_SYNC_POL(1'b0),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .FRAME_CNT_W(4),
`endif
        .COORD_W   (4)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .vga_if(ifb)
    );

    // flags = {h_sync, v_sync, video_on, line_start, frame_start}
    typedef struct {
        int         dut;
        int         x;
        int         y;
        logic [4:0] flags;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    function automatic logic [4:0] flags(input int dut);
        if (dut == 0) return {ifa.h_sync, ifa.v_sync, ifa.video_on, ifa.line_start, ifa.frame_start};
        return {ifb.h_sync, ifb.v_sync, ifb.video_on, ifb.line_start, ifb.frame_start};
    endfunction

    function automatic int cur_x(input int dut);
        return (dut == 0) ? int'(ifa.pixel_x) : int'(ifb.pixel_x);
    endfunction

    function automatic int cur_y(input int dut);
        return (dut == 0) ? int'(ifa.pixel_y) : int'(ifb.pixel_y);
    endfunction

    function automatic logic cur_stb(input int dut);
        return (dut == 0) ? ifa.pix_stb : ifb.pix_stb;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_stb(input int dut, input int x, input int y, input int budget,
                            output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (cur_stb(dut) && cur_x(dut) == x && cur_y(dut) == y) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int budget, output int at);
        bit ok;
        wait_stb(v.dut, v.x, v.y, budget, ok, at);
        check($sformatf("reach d%0d (%0d,%0d)", v.dut, v.x, v.y), int'(ok), 1);
        check($sformatf("flags d%0d (%0d,%0d)", v.dut, v.x, v.y), int'(flags(v.dut)), int'(v.flags));
    endtask

    initial begin
        bit ok;
        int at, r, bad, t_first, t_line1, t_b0, t_b1;

        va.push_back(vec_t'{0, 639, 0, 5'b11100});
        va.push_back(vec_t'{0, 640, 0, 5'b11000});
        va.push_back(vec_t'{0, 655, 0, 5'b11000});
        va.push_back(vec_t'{0, 656, 0, 5'b01000});
        va.push_back(vec_t'{0, 751, 0, 5'b01000});
        va.push_back(vec_t'{0, 752, 0, 5'b11000});
        va.push_back(vec_t'{0, 799, 0, 5'b11000});
        va.push_back(vec_t'{0, 0,   1, 5'b11110});

        vb.push_back(vec_t'{1, 0,  0, 5'b01111});
        vb.push_back(vec_t'{1, 7,  0, 5'b01100});
        vb.push_back(vec_t'{1, 8,  0, 5'b01000});
        vb.push_back(vec_t'{1, 9,  0, 5'b11000});
        vb.push_back(vec_t'{1, 10, 0, 5'b11000});
        vb.push_back(vec_t'{1, 11, 0, 5'b01000});
        vb.push_back(vec_t'{1, 0,  1, 5'b01110});
        vb.push_back(vec_t'{1, 3,  3, 5'b01100});
        vb.push_back(vec_t'{1, 0,  4, 5'b01010});
        vb.push_back(vec_t'{1, 0,  5, 5'b00010});
        vb.push_back(vec_t'{1, 11, 5, 5'b00000});
        vb.push_back(vec_t'{1, 0,  6, 5'b01010});
        vb.push_back(vec_t'{1, 11, 6, 5'b01000});
        vb.push_back(vec_t'{1, 0,  0, 5'b01111});

        rst_a  = 1'b1;
        rst_b  = 1'b1;
        ifa.en = 1'b1;
        ifb.en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("rst_a flags", int'(flags(0)), int'(5'b11000));
        check("rst_a x", cur_x(0), 0);
        check("rst_a y", cur_y(0), 0);
        check("rst_a pix_stb", int'(ifa.pix_stb), 0);
        check("rst_b flags", int'(flags(1)), int'(5'b01000));
        check("rst_b pix_stb", int'(ifb.pix_stb), 0);

        // default instance: first frame, pixel pacing
        @(negedge clk);
        rst_a = 1'b0;
        r = cyc;
        wait_stb(0, 0, 0, 10, ok, at);
        check("a first frame_start found", int'(ok), 1);
        check("a first frame_start latency", at - r, 2);
        check("a first flags", int'(flags(0)), int'(5'b11111));
        t_first = at;
        @(posedge clk);
        #1;
        check("a stb low between pixels", int'(ifa.pix_stb), 0);
        check("a x held between pixels", cur_x(0), 0);
        @(posedge clk);
        #1;
        check("a second pixel stb", int'(ifa.pix_stb), 1);
        check("a second pixel x", cur_x(0), 1);
        check("a second pixel flags", int'(flags(0)), int'(5'b11100));

        for (int i = 0; i < va.size(); i++) begin
            run_vec(va[i], 4000, at);
        end
        t_line1 = at;
        check("a line period", t_line1 - t_first, 1600);

        // enable dropped for 37 clks right after pixel 100 of line 1
        wait_stb(0, 100, 1, 400, ok, at);
        check("a reach x100", int'(ok), 1);
        ifa.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            @(posedge clk);
            #1;
            if (ifa.pix_stb || ifa.line_start || ifa.frame_start || cur_x(0) != 100) bad++;
        end
        check("a frozen cycles with activity", bad, 0);
        ifa.en = 1'b1;
        r = cyc;
        wait_stb(0, 101, 1, 4, ok, at);
        check("a resume x101 found", int'(ok), 1);
        check("a resume latency", at - r, 2);

        // asynchronous reset mid-line
        wait_stb(0, 300, 1, 1000, ok, at);
        check("a reach x300", int'(ok), 1);
        #2;
        rst_a = 1'b1;
        #1;
        check("a async rst flags", int'(flags(0)), int'(5'b11000));
        check("a async rst x", cur_x(0), 0);
        check("a async rst y", cur_y(0), 0);
        check("a async rst stb", int'(ifa.pix_stb), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ifa.pix_stb || ifa.line_start || ifa.frame_start) bad++;
        end
        check("a strobes during rst", bad, 0);
        @(negedge clk);
        rst_a = 1'b0;
        r = cyc;
        wait_stb(0, 0, 0, 10, ok, at);
        check("a post-rst frame_start found", int'(ok), 1);
        check("a post-rst latency", at - r, 2);
        check("a post-rst frame_start", int'(ifa.frame_start), 1);

        // small instance: full frame walk
        @(negedge clk);
        rst_b = 1'b0;
        r = cyc;
        for (int i = 0; i < vb.size(); i++) begin
            run_vec(vb[i], 200, at);
            if (i == 0) t_b0 = at;
        end
        t_b1 = at;
        check("b first frame_start latency", t_b0 - r, 1);
        check("b frame period", t_b1 - t_b0, 84);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!ifb.pix_stb) bad++;
        end
        check("b pix_stb low cycles", bad, 0);

        // small instance: reset mid-frame, frame counter restart
        wait_stb(1, 3, 2, 100, ok, at);
        check("b reach (3,2)", int'(ok), 1);
        #2;
        rst_b = 1'b1;
        #1;
        check("b async rst flags", int'(flags(1)), int'(5'b01000));
        check("b async rst x", cur_x(1), 0);
        check("b async rst y", cur_y(1), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("b async rst frame_cnt", int'(ifb.frame_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("b stb during rst", int'(ifb.pix_stb), 0);
        @(negedge clk);
        rst_b = 1'b0;
        r = cyc;
        wait_stb(1, 0, 0, 10, ok, at);
        check("b post-rst latency", at - r, 1);
        check("b post-rst frame_start", int'(ifb.frame_start), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("b frame_cnt after 1st frame_start", int'(ifb.frame_cnt), 0);
`endif
        t_b0 = at;
        wait_stb(1, 0, 0, 100, ok, at);
        check("b second frame_start found", int'(ok), 1);
        check("b second frame period", at - t_b0, 84);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("b frame_cnt after 2nd frame_start", int'(ifb.frame_cnt), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
